// File: rtl/adc_data_framer.sv
// rtl/adc_data_framer.sv - frames buffered ADC samples with header, count, payload, pad and tail words
module adc_data_framer #(
  parameter int unsigned FRAME_LEN   = 256,
  parameter logic [15:0] HEADER_WORD = 16'hEB90,
  parameter logic [15:0] TAIL_WORD   = 16'h5A5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Acq_Start_Stop,
  input  logic [15:0] Sample_Data,
  input  logic        Sample_Valid,
  input  logic        ext_fifo_full,
  output logic [15:0] ext_fifo_din,
  output logic        ext_fifo_wr_en,
  output logic [15:0] Frame_Count,
  output logic        Overflow_Flag,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_COUNT, S_PAYLOAD, S_PAD, S_TAIL
  } state_t;

  localparam logic [11:0] LAST_IDX = 12'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] mem_q [4];
  logic [15:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] pcnt_q, pcnt_d;
  logic [15:0] fc_q, fc_d;
  logic        ovf_q, ovf_d;
  logic        acq_q, acq_d;
  logic [15:0] din_q, din_d;
  logic        wr_en_q, wr_en_d;

  logic        buf_empty, buf_full, can_write;
  logic        do_write, do_pop, frame_done;
  logic [15:0] word;
  logic        push, drop, arm, flush;

  assign buf_empty = (cnt_q == 3'd0);
  assign buf_full  = (cnt_q == 3'd4);
  assign can_write = !ext_fifo_full;

  // State register plus all datapath flops; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      fc_q     <= '0;
      ovf_q    <= 1'b0;
      acq_q    <= 1'b0;
      din_q    <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      fc_q     <= fc_d;
      ovf_q    <= ovf_d;
      acq_q    <= acq_d;
      din_q    <= din_d;
      wr_en_q  <= wr_en_d;
    end
  end

  // Next-state: every write-state only advances on a cycle the external FIFO has room
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Acq_Start_Stop && !buf_empty) state_d = S_HEADER;
      S_HEADER:  if (can_write) state_d = S_COUNT;
      S_COUNT:   if (can_write) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (can_write) begin
          if (!buf_empty && pcnt_q == LAST_IDX) state_d = S_TAIL;
          else if (buf_empty && !Acq_Start_Stop) state_d = S_PAD;
        end
      end
      S_PAD:     if (can_write && pcnt_q == LAST_IDX) state_d = S_TAIL;
      S_TAIL:    if (can_write) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: which word (if any) goes to the external FIFO this cycle
  always_comb begin
    do_write   = 1'b0;
    do_pop     = 1'b0;
    frame_done = 1'b0;
    word       = '0;
    case (state_q)
      S_HEADER:  if (can_write) begin do_write = 1'b1; word = HEADER_WORD; end
      S_COUNT:   if (can_write) begin do_write = 1'b1; word = fc_q; end
      S_PAYLOAD: if (can_write && !buf_empty) begin
        do_write = 1'b1;
        do_pop   = 1'b1;
        word     = mem_q[rd_ptr_q];
      end
      S_PAD:     if (can_write) begin do_write = 1'b1; word = 16'h0000; end
      S_TAIL:    if (can_write) begin do_write = 1'b1; word = TAIL_WORD; frame_done = 1'b1; end
      default:   ;
    endcase
  end

  // Sample buffer, counters and sticky flag; a full buffer drops even if a pop happens this cycle
  always_comb begin
    arm   = (state_q == S_IDLE) && Acq_Start_Stop && !acq_q;
    push  = Sample_Valid && Acq_Start_Stop && !buf_full;
    drop  = Sample_Valid && buf_full;
    flush = !Acq_Start_Stop && (frame_done || state_q == S_IDLE);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = Sample_Data;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 2'd1;
      cnt_d = cnt_q + {2'b00, push} - {2'b00, do_pop};
    end

    pcnt_d = pcnt_q;
    if (frame_done) pcnt_d = '0;
    else if (do_write && (state_q == S_PAYLOAD || state_q == S_PAD)) pcnt_d = pcnt_q + 12'd1;

    fc_d = fc_q;
    if (arm) fc_d = '0;
    else if (frame_done) fc_d = fc_q + 16'd1;

    ovf_d = ovf_q;
    if (arm) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;

    acq_d   = Acq_Start_Stop;
    wr_en_d = do_write;
    din_d   = do_write ? word : din_q;
  end

  assign ext_fifo_din   = din_q;
  assign ext_fifo_wr_en = wr_en_q;
  assign Frame_Count    = fc_q;
  assign Overflow_Flag  = ovf_q;
  assign Busy           = (state_q != S_IDLE);

endmodule

// File: doc/adc_data_framer.md
ADC_DATA_FRAMER -- requirements
Module: adc_data_framer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 256, meaning payload words per frame; legal range 1..4095.
REQ-002 SHALL have parameter HEADER_WORD, default 16'hEB90, meaning first word of every frame.
REQ-003 SHALL have parameter TAIL_WORD, default 16'h5A5A, meaning last word of every frame.
REQ-004 SHALL have port clk  input  1  sole clock; the acquisition (clk) domain. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Acq_Start_Stop  input  1  acquisition enable, level, already in the clk domain.
REQ-007 SHALL have port Sample_Data  input  16  ADC sample word.
REQ-008 SHALL have port Sample_Valid  input  1  one-cycle qualifier for Sample_Data.
REQ-009 SHALL have port ext_fifo_full  input  1  programmable-full of the external FIFO, asserted with at least 2 free entries remaining.
REQ-010 SHALL have port ext_fifo_din  output  16  word written to the external FIFO.
REQ-011 SHALL have port ext_fifo_wr_en  output  1  write strobe to the external FIFO.
REQ-012 SHALL have port Frame_Count  output  16  number of completed frames.
REQ-013 SHALL have port Overflow_Flag  output  1  sticky flag: at least one sample was dropped.
REQ-014 SHALL have port Busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 SHALL buffer accepted samples in a 4-entry internal FIFO; a sample is accepted when Sample_Valid=1 and Acq_Start_Stop=1.
REQ-016 SHALL drop the sample and set Overflow_Flag when Sample_Valid=1 and the buffer is full; a pop in the same cycle does not free space for that sample.
REQ-017 SHALL implement FSM states IDLE, HEADER, COUNT, PAYLOAD, PAD, TAIL.
REQ-018 IDLE->HEADER SHALL occur when Acq_Start_Stop=1 and the buffer is non-empty.
REQ-019 HEADER writes HEADER_WORD and then goes to COUNT; COUNT writes Frame_Count and then goes to PAYLOAD.
REQ-020 PAYLOAD SHALL pop one buffered word and write it whenever the buffer is non-empty; after FRAME_LEN payload writes it SHALL go to TAIL.
REQ-021 SHALL go from PAYLOAD to PAD when Acq_Start_Stop=0 and the buffer is empty. PAD writes 16'h0000 until FRAME_LEN payload words total have been written, then goes to TAIL.
REQ-022 TAIL SHALL write TAIL_WORD, increment Frame_Count (wrapping 16'hFFFF->0), and go to IDLE.
REQ-023 Every write SHALL occur only in a cycle where ext_fifo_full=0 is sampled. When full=1, the FSM holds state and counters; no word is skipped or duplicated.
REQ-024 ext_fifo_din and ext_fifo_wr_en SHALL be registered, one cycle after the deciding edge; wr_en is high for exactly one cycle per word.
REQ-025 SHALL clear Frame_Count and Overflow_Flag on a 0->1 edge of Acq_Start_Stop detected while in IDLE.
REQ-026 Every frame SHALL be exactly FRAME_LEN+3 words; a frame is never truncated once HEADER is entered.
REQ-027 SHALL flush any samples left in the buffer when returning to IDLE with Acq_Start_Stop=0.

Reset
REQ-028 On reset=1 the block SHALL return to IDLE, empty the buffer, and drive ext_fifo_wr_en=0, ext_fifo_din=0, Frame_Count=0, Overflow_Flag=0, Busy=0, whatever the current state.
REQ-029 Reset mid-frame SHALL abandon the partial frame; the next frame starts with HEADER_WORD.

Verification (FRAME_LEN=4)
REQ-030 Acq=1 with samples 1,2,3,4 one per cycle and full=0 -> writes EB90,0000,0001,0002,0003,0004,5A5A; then Frame_Count=1.
REQ-031 A second frame of samples 5..8 -> count word 0001, then Frame_Count=2. Preload Frame_Count=FFFF and complete one frame -> Frame_Count=0000.
REQ-032 Hold full=1 for 5 cycles during PAYLOAD after 2 words -> no wr_en while full; the output sequence is identical to REQ-030.
REQ-033 Full held for 6 cycles while 6 samples arrive -> 2 samples dropped, Overflow_Flag=1, frame length still 7 words.
REQ-034 Acq drops after sample 2 -> writes EB90,0000,0001,0002,0000,0000,5A5A; Busy=0 afterwards.
REQ-035 Assert reset during COUNT -> next edge shows wr_en=0, Busy=0, Frame_Count=0; after release, the next frame begins with EB90.
